sc_tapped_delay_line: RTL and testbench
=======================================

// Module: sc_tapped_delay_line
// PURPOSE
//  Multi-channel, runtime-tappable delay line for stochastic bitstreams.
//  - Delays WIDTH parallel channels by a selectable number of enabled shifts.
//  - Optional recirculation turns the register chain into a rotating buffer.
//  - Used to decorrelate bitstreams ahead of SC multipliers/adders.
//  - Tracks fill level so downstream logic knows when the selected tap holds real data.
// PARAMETERS
//  WIDTH  1  channels (bits per stage); WIDTH >= 1
//  DEPTH  8  number of stages; DEPTH >= 1
//  SEL_W  derived localparam = (DEPTH>1) ? $clog2(DEPTH) : 1; not overridable
//  CNT_W  derived localparam = $clog2(DEPTH+1); width of internal fill counter
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  rst       in   1      asynchronous, active-low reset
//  en        in   1      shift enable; chain advances only on edges with en=1
//  flush     in   1      synchronous clear of stages and fill count
//  recirc    in   1      1: stage0 loads stage[DEPTH-1] instead of data_in
//  tap_sel   in   SEL_W  output tap select, 0..DEPTH-1 (values above are clamped)
//  data_in   in   WIDTH  input sample, captured on enabled edges
//  data_out  out  WIDTH  stage[tap_sel_eff], combinational mux of registers
//  tail_out  out  WIDTH  stage[DEPTH-1]
//  primed    out  1      fill_cnt > tap_sel_eff: data_out holds a real sample
//  full      out  1      fill_cnt == DEPTH
// BEHAVIOUR
//  - State: stage[0..DEPTH-1] (WIDTH bits each), fill_cnt (CNT_W bits, 0..DEPTH).
//  - Reset: rst=0 asynchronously clears all stages and fill_cnt.
//    - Outputs go to 0 immediately: data_out, tail_out, primed, full.
//    - Reset takes effect regardless of en/flush and at any point mid-stream.
//  - Priority per edge: rst > flush > en > hold.
//  - flush=1: all stages <= 0, fill_cnt <= 0.
//    - en/recirc/data_in are ignored that cycle; the sample is dropped.
//  - en=1, recirc=0 (linear shift):
//    - stage[0] <= data_in; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
//    - fill_cnt <= min(fill_cnt+1, DEPTH) (saturating).
//  - en=1, recirc=1 (rotate):
//    - stage[0] <= stage[DEPTH-1]; stage[i] <= stage[i-1]; data_in is ignored.
//    - fill_cnt is held.
//  - en=0: all state held; recirc and data_in are don't-care.
//  - tap_sel_eff = (tap_sel > DEPTH-1) ? DEPTH-1 : tap_sel.
//    - Combinational, so a tap_sel change is visible on data_out in the same cycle.
//  - Latency: a sample accepted on enabled edge k is on data_out after edge k+tap_sel_eff.
//    - That is tap_sel_eff+1 enabled edges, counting edge k itself.
//    - It reaches tail_out after DEPTH enabled edges.
//  - primed and full are combinational from fill_cnt and tap_sel_eff.
//    - primed drops immediately if tap_sel is raised beyond the current fill level.
//  - DEPTH=1: a single stage; tap_sel is ignored; data_out == tail_out.
//  - Stages and fill_cnt are all reset with the same asynchronous reset; no X on outputs after reset.
// TESTING
//  1. WIDTH=4, DEPTH=8, tap_sel=2, en=1, data_in=1,2,3,... per cycle
//     -> data_out = 1 after the 3rd edge, then 2,3,...; primed rises after the 3rd edge.
//     -> full rises after the 8th edge; tail_out = 1 after the 8th edge.
//  2. Same setup, en pattern 1,0,0,1,1 with data_in 5,x,x,6,7 and tap_sel=1
//     -> data_out advances only on enabled edges; 5 appears after the 4th edge (2nd enabled edge).
//  3. Fill 8 samples A0..A7, then recirc=1, en=1 for 16 cycles
//     -> tail_out sequence repeats with period 8; full stays 1; data_in changes have no effect.
//  4. Mid-stream, assert flush=1 together with en=1, data_in=F
//     -> next cycle all outputs = 0, primed=0, full=0; F never appears at any tap.
//  5. Drive rst=0 between edges while streaming
//     -> outputs go 0 before the next edge; after release, primed stays 0 until tap_sel_eff+1 enabled edges.
//  6. DEPTH=5, tap_sel=7
//     -> behaves as tap 4: data_out == tail_out; primed == full.

Source files
------------

// File: rtl/sc_tapped_delay_line.sv
// Multi-channel tapped delay line for stochastic bitstreams, with optional
// recirculation (rotating buffer) and a fill counter that qualifies the selected tap.
module sc_tapped_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             recirc,
  input  logic [SEL_W-1:0] tap_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] tail_out,
  output logic             primed,
  output logic             full
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CNT_W-1:0] r_fill;
  logic [SEL_W-1:0] w_tap_eff;

  // Priority: reset > flush > enabled shift/rotate > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_fill <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_fill <= '0;
    end else if (en) begin
      r_stage[0] <= recirc ? r_stage[DEPTH-1] : data_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      // Rotation only reorders existing samples, so the fill level is unchanged.
      if (!recirc && (r_fill != FILL_MAX)) begin
        r_fill <= r_fill + CNT_W'(1);
      end
    end
  end

  generate
    if (DEPTH == 1) begin : g_single
      logic w_unused_sel;
      assign w_unused_sel = ^tap_sel;
      assign w_tap_eff    = '0;
    end else if ((1 << SEL_W) > DEPTH) begin : g_clamp
      localparam logic [SEL_W-1:0] MAX_TAP = SEL_W'(DEPTH - 1);
      assign w_tap_eff = (tap_sel > MAX_TAP) ? MAX_TAP : tap_sel;
    end else begin : g_pow2
      assign w_tap_eff = tap_sel;
    end
  endgenerate

  assign data_out = r_stage[w_tap_eff];
  assign tail_out = r_stage[DEPTH-1];
  assign primed   = (r_fill > CNT_W'(w_tap_eff));
  assign full     = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_sc_tapped_delay_line.sv
// Directed bench for sc_tapped_delay_line: an 8-deep and a 5-deep instance,
// hand-computed expectations, one checking task, one summary line.
module tb_sc_tapped_delay_line;

  logic       clk = 1'b0;
  logic       rst;

  logic       en, flush, recirc;
  logic [2:0] tap_sel;
  logic [3:0] data_in;
  logic [3:0] data_out, tail_out;
  logic       primed, full;

  logic       en_b, flush_b, recirc_b;
  logic [2:0] tap_sel_b;
  logic [3:0] data_in_b;
  logic [3:0] data_out_b, tail_out_b;
  logic       primed_b, full_b;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] a_val [8];

  always #5 clk = ~clk;

  sc_tapped_delay_line #(.WIDTH(4), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .recirc(recirc),
    .tap_sel(tap_sel), .data_in(data_in), .data_out(data_out),
    .tail_out(tail_out), .primed(primed), .full(full)
  );

  sc_tapped_delay_line #(.WIDTH(4), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .en(en_b), .flush(flush_b), .recirc(recirc_b),
    .tap_sel(tap_sel_b), .data_in(data_in_b), .data_out(data_out_b),
    .tail_out(tail_out_b), .primed(primed_b), .full(full_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; recirc = 1'b0; tap_sel = 3'd0; data_in = 4'd0;
    en_b = 1'b0; flush_b = 1'b0; recirc_b = 1'b0; tap_sel_b = 3'd0; data_in_b = 4'd0;
    #1 rst = 1'b0;
    #2;
    check("rst_out",    32'(data_out),   32'd0);
    check("rst_tail",   32'(tail_out),   32'd0);
    check("rst_primed", 32'(primed),     32'd0);
    check("rst_full",   32'(full),       32'd0);
    check("rst_b_out",  32'(data_out_b), 32'd0);
    check("rst_b_full", 32'(full_b),     32'd0);
    #9 rst = 1'b1;

    // Test 1: linear fill, tap 2, sample k on edge k
    tap_sel = 3'd2;
    for (int k = 1; k <= 10; k++) begin
      en = 1'b1; data_in = 4'(k);
      step();
      check($sformatf("t1_out_%0d", k),    32'(data_out), (k >= 3) ? 32'(k - 2) : 32'd0);
      check($sformatf("t1_primed_%0d", k), 32'(primed),   (k >= 3) ? 32'd1 : 32'd0);
      check($sformatf("t1_full_%0d", k),   32'(full),     (k >= 8) ? 32'd1 : 32'd0);
      check($sformatf("t1_tail_%0d", k),   32'(tail_out), (k >= 8) ? 32'(k - 7) : 32'd0);
    end
    // Stages now hold 10..3; the tap mux is combinational, including clamping.
    en = 1'b0;
    tap_sel = 3'd5; #1;
    check("t1_tap5", 32'(data_out), 32'd5);
    tap_sel = 3'd7; #1;
    check("t1_tap7", 32'(data_out), 32'd3);

    // Test 2: enable gaps, tap 1
    flush = 1'b1; step(); flush = 1'b0;
    check("t2_flush_out",  32'(data_out), 32'd0);
    check("t2_flush_full", 32'(full),     32'd0);
    tap_sel = 3'd1;
    en = 1'b1; data_in = 4'd5; step();
    check("t2_e1_out",    32'(data_out), 32'd0);
    check("t2_e1_primed", 32'(primed),   32'd0);
    en = 1'b0; data_in = 4'($urandom_range(0, 15)); step();
    check("t2_e2_out", 32'(data_out), 32'd0);
    data_in = 4'($urandom_range(0, 15)); step();
    check("t2_e3_out",    32'(data_out), 32'd0);
    check("t2_e3_primed", 32'(primed),   32'd0);
    en = 1'b1; data_in = 4'd6; step();
    check("t2_e4_out",    32'(data_out), 32'd5);
    check("t2_e4_primed", 32'(primed),   32'd1);
    data_in = 4'd7; step();
    check("t2_e5_out", 32'(data_out), 32'd6);

    // Test 3: fill A0..A7 then rotate for 16 edges
    for (int i = 0; i < 8; i++) a_val[i] = 4'(3 * i + 1);
    en = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    tap_sel = 3'd3;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; recirc = 1'b0; data_in = a_val[i];
      step();
    end
    check("t3_fill_tail", 32'(tail_out), 32'(a_val[0]));
    check("t3_fill_full", 32'(full),     32'd1);
    check("t3_fill_out",  32'(data_out), 32'(a_val[4]));
    recirc = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      data_in = 4'($urandom_range(0, 15));
      step();
      check($sformatf("t3_tail_%0d", r), 32'(tail_out), 32'(a_val[r % 8]));
      check($sformatf("t3_out_%0d", r),  32'(data_out), 32'(a_val[(r + 4) % 8]));
      check($sformatf("t3_full_%0d", r), 32'(full),     32'd1);
    end
    recirc = 1'b0;

    // Test 4: flush wins over a simultaneous enabled sample
    tap_sel = 3'd0;
    for (int k = 1; k <= 3; k++) begin
      en = 1'b1; data_in = 4'(k); step();
    end
    flush = 1'b1; en = 1'b1; data_in = 4'hF; step(); flush = 1'b0;
    check("t4_out",    32'(data_out), 32'd0);
    check("t4_tail",   32'(tail_out), 32'd0);
    check("t4_primed", 32'(primed),   32'd0);
    check("t4_full",   32'(full),     32'd0);
    for (int k = 1; k <= 8; k++) begin
      en = 1'b1; data_in = 4'd2; step();
      check($sformatf("t4_post_out_%0d", k),  32'(data_out), 32'd2);
      check($sformatf("t4_post_tail_%0d", k), 32'(tail_out), (k == 8) ? 32'd2 : 32'd0);
      check($sformatf("t4_post_full_%0d", k), 32'(full),     (k == 8) ? 32'd1 : 32'd0);
    end

    // Test 5: asynchronous reset between edges while streaming
    tap_sel = 3'd2;
    for (int k = 5; k <= 8; k++) begin
      en = 1'b1; data_in = 4'(k); step();
    end
    check("t5_pre_out",  32'(data_out), 32'd6);
    check("t5_pre_tail", 32'(tail_out), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_out",    32'(data_out), 32'd0);
    check("t5_rst_tail",   32'(tail_out), 32'd0);
    check("t5_rst_primed", 32'(primed),   32'd0);
    check("t5_rst_full",   32'(full),     32'd0);
    #1 rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      en = 1'b1; data_in = 4'(8 + k); step();
      check($sformatf("t5_primed_%0d", k), 32'(primed),   (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("t5_out_%0d", k),    32'(data_out), (k == 3) ? 32'd9 : 32'd0);
    end
    en = 1'b0;

    // Test 6: DEPTH=5 with tap_sel=7 clamps to tap 4
    tap_sel_b = 3'd7;
    for (int k = 1; k <= 7; k++) begin
      en_b = 1'b1; data_in_b = 4'(k); step();
      check($sformatf("t6_out_%0d", k),    32'(data_out_b), (k >= 5) ? 32'(k - 4) : 32'd0);
      check($sformatf("t6_tail_%0d", k),   32'(tail_out_b), (k >= 5) ? 32'(k - 4) : 32'd0);
      check($sformatf("t6_primed_%0d", k), 32'(primed_b),   (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("t6_full_%0d", k),   32'(full_b),     (k >= 5) ? 32'd1 : 32'd0);
    end
    en_b = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
